// File: rtl/am_envelope_demod.sv
// AM envelope detector: rectify or square, accumulate-and-dump by DEC, moving average over 2^AVG_LOG2 dumps.
// Latency: DEC-th sample of a block accepted in cycle T gives a dout_valid pulse in cycle T+4.
// No backpressure: a sample is taken on every cycle din_valid is high; idle cycles freeze the datapath.
module am_envelope_demod #(
    parameter int DIN_W    = 12,
    parameter int DOUT_W   = 14,
    parameter int DEC      = 50,
    parameter int AVG_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DIN_W-1:0] din,
    input  logic                    din_valid,
    input  logic [1:0]              mode,
    input  logic [2:0]              gain_sh,
    output logic [DOUT_W-1:0]       dout,
    output logic                    dout_valid,
    output logic                    sat
);

    localparam int M      = DIN_W - 1;
    localparam int CW     = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int AW     = M + CW;
    localparam int SW     = AW + AVG_LOG2;
    localparam int N      = 1 << AVG_LOG2;
    localparam int RSH    = (SW >= DOUT_W) ? SW - DOUT_W : 0;
    localparam int LSH    = (SW < DOUT_W) ? DOUT_W - SW : 0;
    localparam int OW     = SW + 7 + LSH;
    localparam int DEC_M1 = DEC - 1;
    localparam int N_M1   = N - 1;

    localparam logic [CW-1:0]       CNT_MAX   = DEC_M1[CW-1:0];
    localparam logic [AVG_LOG2:0]   FILL_N    = N[AVG_LOG2:0];
    localparam logic [AVG_LOG2:0]   FILL_LAST = N_M1[AVG_LOG2:0];
    localparam logic [M-1:0]        R_MAX     = {M{1'b1}};

    // Mode control: 11 aliases to 00 so it is never seen as a change.
    logic [1:0] mode_n;
    logic [1:0] mode_q;
    logic [2:0] gain_q;
    logic       primed;
    logic       flush;

    assign mode_n = (mode == 2'b11) ? 2'b00 : mode;
    assign flush  = primed && (mode_n != mode_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 2'b00;
            gain_q <= 3'd0;
            primed <= 1'b0;
        end else begin
            mode_q <= mode_n;
            gain_q <= gain_sh;
            primed <= 1'b1;
        end
    end

    // Detector
    logic [DIN_W-1:0]   din_u;
    logic [DIN_W-1:0]   mag;
    logic [2*DIN_W-1:0] sq;
    logic [2*DIN_W-1:0] sq_sh;
    logic               sq_sat;
    logic [M-1:0]       det;

    assign din_u  = din;
    assign mag    = din[DIN_W-1] ? (~din_u + DIN_W'(1)) : din_u;
    assign sq     = {{DIN_W{1'b0}}, mag} * {{DIN_W{1'b0}}, mag};
    assign sq_sh  = sq >> M;
    assign sq_sat = |sq_sh[2*DIN_W-1:M];

    // The incoming mode drives detection so the sample landing on a flush edge already belongs to the new mode.
    always_comb begin
        det = '0;
        case (mode_n)
            2'b01:   det = din[DIN_W-1] ? '0 : din_u[M-1:0];
            2'b10:   det = sq_sat ? R_MAX : sq_sh[M-1:0];
            default: det = mag[DIN_W-1] ? R_MAX : mag[M-1:0];
        endcase
    end

    logic [M-1:0] r;
    logic         r_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r     <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= din_valid;
            if (din_valid) begin
                r <= det;
            end
        end
    end

    // Accumulate-and-dump
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt;
    logic [AW-1:0] dump;
    logic          dump_vld;

    assign acc_sum = acc + {{CW{1'b0}}, r};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            cnt      <= '0;
            dump     <= '0;
            dump_vld <= 1'b0;
        end else if (flush) begin
            acc      <= '0;
            cnt      <= '0;
            dump_vld <= 1'b0;
        end else begin
            dump_vld <= 1'b0;
            if (r_vld) begin
                if (cnt == CNT_MAX) begin
                    dump     <= acc_sum;
                    dump_vld <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Moving-average history and running sum
    logic [AW-1:0]       hist [N];
    logic [AVG_LOG2-1:0] ptr;
    logic [AVG_LOG2:0]   fill;
    logic [SW-1:0]       s;
    logic [SW-1:0]       s_next;
    logic                s_vld;
    logic                s_warm;

    assign s_next = s + {{AVG_LOG2{1'b0}}, dump} - {{AVG_LOG2{1'b0}}, hist[ptr]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            ptr    <= '0;
            fill   <= '0;
            s      <= '0;
            s_vld  <= 1'b0;
            s_warm <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            ptr    <= '0;
            fill   <= '0;
            s      <= '0;
            s_vld  <= 1'b0;
            s_warm <= 1'b0;
        end else begin
            s_vld <= dump_vld;
            if (dump_vld) begin
                hist[ptr] <= dump;
                ptr       <= ptr + AVG_LOG2'(1);
                s         <= s_next;
                s_warm    <= (fill >= FILL_LAST);
                if (fill != FILL_N) begin
                    fill <= fill + (AVG_LOG2 + 1)'(1);
                end
            end
        end
    end

    // Output scaling and clipping; dout/sat hold between pulses and through a flush.
    logic [OW-1:0] s_ext;
    logic [OW-1:0] shifted;
    logic          over;

    assign s_ext   = {{(OW - SW){1'b0}}, s};
    assign shifted = ((s_ext << gain_q) << LSH) >> RSH;
    assign over    = |shifted[OW-1:DOUT_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sat        <= 1'b0;
        end else if (flush) begin
            dout_valid <= 1'b0;
        end else if (s_vld && s_warm) begin
            dout       <= over ? {DOUT_W{1'b1}} : shifted[DOUT_W-1:0];
            sat        <= over;
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_am_envelope_demod.sv
// Directed bench for am_envelope_demod with DEC=4, AVG_LOG2=2 (S is 15 bits, output drops 1 LSB).
module tb_am_envelope_demod;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [11:0] din;
    logic               din_valid;
    logic [1:0]         mode;
    logic [2:0]         gain_sh;
    logic [13:0]        dout;
    logic               dout_valid;
    logic               sat;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc;
    int pulse_cyc[$];
    int pulse_dout[$];
    int pulse_sat[$];

    always #5 clk = ~clk;

    am_envelope_demod #(
        .DIN_W(12), .DOUT_W(14), .DEC(4), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .mode(mode),
        .gain_sh(gain_sh), .dout(dout), .dout_valid(dout_valid), .sat(sat)
    );

    task automatic clear_log();
        cyc = 0;
        pulse_cyc.delete();
        pulse_dout.delete();
        pulse_sat.delete();
    endtask

    // Each negedge: log the current cycle's outputs, then drive that cycle's input.
    task automatic run(input logic signed [11:0] d, input bit toggle, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                pulse_cyc.push_back(cyc);
                pulse_dout.push_back(int'(dout));
                pulse_sat.push_back(int'(sat));
            end
            din       = d;
            din_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            cyc++;
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        mode      = m;
        gain_sh   = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; din_valid = 1'b0; mode = 2'b00; gain_sh = 3'd0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (dout !== 14'd0) begin err_cnt++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        vec_cnt++;
        if (dout_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_dout_valid: got %0b expected 0", dout_valid); end
        vec_cnt++;
        if (sat !== 1'b0) begin err_cnt++; $display("FAIL reset_sat: got %0b expected 0", sat); end
    endtask

    task automatic test_full_wave();
        do_reset(2'b00);
        run(12'sd100, 1'b0, 30);
        vec_cnt++;
        if (pulse_cyc.size() != 3) begin err_cnt++; $display("FAIL fw_pulse_count: got %0d expected 3", pulse_cyc.size()); end
        vec_cnt++;
        if (pulse_cyc.size() < 1 || pulse_cyc[0] != 19) begin err_cnt++; $display("FAIL fw_first_pulse_cycle: got %0d expected 19", pulse_cyc.size() ? pulse_cyc[0] : -1); end
        vec_cnt++;
        if (pulse_dout.size() < 1 || pulse_dout[0] != 800) begin err_cnt++; $display("FAIL fw_dout: got %0d expected 800", pulse_dout.size() ? pulse_dout[0] : -1); end
        vec_cnt++;
        if (pulse_sat.size() < 1 || pulse_sat[0] != 0) begin err_cnt++; $display("FAIL fw_sat: got %0d expected 0", pulse_sat.size() ? pulse_sat[0] : -1); end
        vec_cnt++;
        if (pulse_cyc.size() < 2 || pulse_cyc[1] - pulse_cyc[0] != 4) begin err_cnt++; $display("FAIL fw_spacing: got %0d expected 4", pulse_cyc.size() > 1 ? pulse_cyc[1] - pulse_cyc[0] : -1); end
    endtask

    task automatic test_saturation();
        do_reset(2'b00);
        run(-12'sd2048, 1'b0, 22);
        vec_cnt++;
        if (pulse_dout.size() < 1 || pulse_dout[0] != 16376) begin err_cnt++; $display("FAIL min_fw_dout: got %0d expected 16376", pulse_dout.size() ? pulse_dout[0] : -1); end
        vec_cnt++;
        if (pulse_sat.size() < 1 || pulse_sat[0] != 0) begin err_cnt++; $display("FAIL min_fw_sat: got %0d expected 0", pulse_sat.size() ? pulse_sat[0] : -1); end
        gain_sh = 3'd1;
        run(-12'sd2048, 1'b0, 8);
        vec_cnt++;
        if (pulse_dout.size() < 2 || pulse_dout[1] != 16383) begin err_cnt++; $display("FAIL gain_clip_dout: got %0d expected 16383", pulse_dout.size() > 1 ? pulse_dout[1] : -1); end
        vec_cnt++;
        if (pulse_sat.size() < 2 || pulse_sat[1] != 1) begin err_cnt++; $display("FAIL gain_clip_sat: got %0d expected 1", pulse_sat.size() > 1 ? pulse_sat[1] : -1); end
    endtask

    task automatic test_half_square();
        do_reset(2'b01);
        run(-12'sd100, 1'b0, 22);
        vec_cnt++;
        if (pulse_cyc.size() < 1 || pulse_cyc[0] != 19) begin err_cnt++; $display("FAIL hw_pulse_cycle: got %0d expected 19", pulse_cyc.size() ? pulse_cyc[0] : -1); end
        vec_cnt++;
        if (pulse_dout.size() < 1 || pulse_dout[0] != 0) begin err_cnt++; $display("FAIL hw_dout: got %0d expected 0", pulse_dout.size() ? pulse_dout[0] : -1); end
        do_reset(2'b10);
        run(12'sd1024, 1'b0, 22);
        vec_cnt++;
        if (pulse_dout.size() < 1 || pulse_dout[0] != 4096) begin err_cnt++; $display("FAIL sq_dout: got %0d expected 4096", pulse_dout.size() ? pulse_dout[0] : -1); end
        run(-12'sd2048, 1'b0, 24);
        vec_cnt++;
        if (pulse_cyc.size() != 7 || pulse_dout[6] != 16376) begin err_cnt++; $display("FAIL sq_min_clip_dout: got %0d expected 16376", pulse_dout.size() ? pulse_dout[pulse_dout.size()-1] : -1); end
        vec_cnt++;
        if (pulse_sat.size() != 7 || pulse_sat[6] != 0) begin err_cnt++; $display("FAIL sq_min_clip_sat: got %0d expected 0", pulse_sat.size() ? pulse_sat[pulse_sat.size()-1] : -1); end
    endtask

    task automatic test_mode_switch();
        do_reset(2'b00);
        run(12'sd100, 1'b0, 22);
        vec_cnt++;
        if (pulse_dout.size() != 1 || pulse_dout[0] != 800) begin err_cnt++; $display("FAIL ms_pre_dout: got %0d expected 800", pulse_dout.size() ? pulse_dout[0] : -1); end
        mode = 2'b10;
        run(12'sd100, 1'b0, 10);
        vec_cnt++;
        if (pulse_cyc.size() != 1) begin err_cnt++; $display("FAIL ms_flush_quiet: got %0d pulses expected 1", pulse_cyc.size()); end
        vec_cnt++;
        if (dout !== 14'd800) begin err_cnt++; $display("FAIL ms_dout_hold: got %0d expected 800", dout); end
        run(12'sd100, 1'b0, 14);
        vec_cnt++;
        if (pulse_cyc.size() < 2 || pulse_cyc[1] != 40) begin err_cnt++; $display("FAIL ms_post_cycle: got %0d expected 40", pulse_cyc.size() > 1 ? pulse_cyc[1] : -1); end
        vec_cnt++;
        if (pulse_dout.size() < 2 || pulse_dout[1] != 32) begin err_cnt++; $display("FAIL ms_post_dout: got %0d expected 32", pulse_dout.size() > 1 ? pulse_dout[1] : -1); end
    endtask

    task automatic test_back_to_back();
        do_reset(2'b00);
        run(12'sd100, 1'b1, 44);
        vec_cnt++;
        if (pulse_cyc.size() != 2) begin err_cnt++; $display("FAIL tg_pulse_count: got %0d expected 2", pulse_cyc.size()); end
        vec_cnt++;
        if (pulse_cyc.size() < 1 || pulse_cyc[0] != 34) begin err_cnt++; $display("FAIL tg_first_cycle: got %0d expected 34", pulse_cyc.size() ? pulse_cyc[0] : -1); end
        vec_cnt++;
        if (pulse_cyc.size() < 2 || pulse_cyc[1] - pulse_cyc[0] != 8) begin err_cnt++; $display("FAIL tg_spacing: got %0d expected 8", pulse_cyc.size() > 1 ? pulse_cyc[1] - pulse_cyc[0] : -1); end
        vec_cnt++;
        if (pulse_dout.size() < 2 || pulse_dout[0] != 800 || pulse_dout[1] != 800) begin err_cnt++; $display("FAIL tg_dout: got %0d expected 800", pulse_dout.size() > 1 ? pulse_dout[1] : -1); end
    endtask

    task automatic test_reset_mid_block();
        do_reset(2'b00);
        run(12'sd100, 1'b0, 30);
        vec_cnt++;
        if (dout !== 14'd800) begin err_cnt++; $display("FAIL rm_pre_dout: got %0d expected 800", dout); end
        clear_log();
        run(12'sd100, 1'b0, 9);
        @(negedge clk);
        din_valid = 1'b1;
        rst       = 1'b0;
        #1;
        vec_cnt++;
        if (dout !== 14'd0) begin err_cnt++; $display("FAIL rm_dout: got %0d expected 0", dout); end
        vec_cnt++;
        if (dout_valid !== 1'b0) begin err_cnt++; $display("FAIL rm_dout_valid: got %0b expected 0", dout_valid); end
        vec_cnt++;
        if (sat !== 1'b0) begin err_cnt++; $display("FAIL rm_sat: got %0b expected 0", sat); end
        do_reset(2'b00);
        run(12'sd100, 1'b0, 22);
        vec_cnt++;
        if (pulse_cyc.size() != 1 || pulse_cyc[0] != 19) begin err_cnt++; $display("FAIL rm_restart_cycle: got %0d expected 19", pulse_cyc.size() ? pulse_cyc[0] : -1); end
        vec_cnt++;
        if (pulse_dout.size() < 1 || pulse_dout[0] != 800) begin err_cnt++; $display("FAIL rm_restart_dout: got %0d expected 800", pulse_dout.size() ? pulse_dout[0] : -1); end
    endtask

    initial begin
        test_reset();
        test_full_wave();
        test_saturation();
        test_half_square();
        test_mode_switch();
        test_back_to_back();
        test_reset_mid_block();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
